// File: rtl/song_reader_if.sv
// Bus between the song reader and its environment: player controls, note ROM
// port, and the note/duration hand-off to the note player.
interface song_reader_if #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
);
    logic                      play;
    logic [1:0]                song;
    logic                      note_done;
    logic [2+IDX_W-1:0]        rom_addr;
    logic [NOTE_W+DUR_W-1:0]   rom_data;
    logic [NOTE_W-1:0]         note;
    logic [DUR_W-1:0]          duration;
    logic                      new_note;
    logic                      song_done;

    modport master (
        output play, song, note_done, rom_data,
        input  rom_addr, note, duration, new_note, song_done
    );

    modport slave (
        input  play, song, note_done, rom_data,
        output rom_addr, note, duration, new_note, song_done
    );
endinterface

// File: rtl/song_reader.sv
// Walks the external note ROM for the selected song and presents one
// note/duration pair at a time, advancing on each note_done pulse.
module song_reader #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6,
    parameter int IDX_W  = 5
) (
    input  logic        clk,
    input  logic        reset,
    song_reader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_ROM,
        WAIT_NOTE,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    note_idx, note_idx_nx;
    logic [NOTE_W-1:0]   note_q, note_nx;
    logic [DUR_W-1:0]    dur_q, dur_nx;
    logic                new_note_q, new_note_nx;
    logic                song_done_q, song_done_nx;

    logic [NOTE_W-1:0]   rom_note;
    logic [DUR_W-1:0]    rom_dur;

    function automatic logic is_end_marker(input logic [DUR_W-1:0] dur);
        return (dur == '0);
    endfunction

    assign rom_note = bus.rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = bus.rom_data[DUR_W-1:0];

    // Song is not latched: a song change always comes with a reset.
    assign bus.rom_addr  = {bus.song, note_idx};
    assign bus.note      = note_q;
    assign bus.duration  = dur_q;
    assign bus.new_note  = new_note_q;
    assign bus.song_done = song_done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            note_idx    <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            new_note_q  <= 1'b0;
            song_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            note_idx    <= note_idx_nx;
            note_q      <= note_nx;
            dur_q       <= dur_nx;
            new_note_q  <= new_note_nx;
            song_done_q <= song_done_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        note_idx_nx  = note_idx;
        note_nx      = note_q;
        dur_nx       = dur_q;
        new_note_nx  = 1'b0;
        song_done_nx = 1'b0;

        case (state)
            IDLE: begin
                if (bus.play) state_nx = FETCH;
            end
            FETCH: begin
                state_nx = WAIT_ROM;
            end
            WAIT_ROM: begin
                // ROM word stays valid while paused since the address is held.
                if (bus.play) begin
                    if (is_end_marker(rom_dur)) begin
                        song_done_nx = 1'b1;
                        state_nx     = DONE;
                    end else begin
                        note_nx     = rom_note;
                        dur_nx      = rom_dur;
                        new_note_nx = 1'b1;
                        state_nx    = WAIT_NOTE;
                    end
                end
            end
            WAIT_NOTE: begin
                if (bus.note_done) begin
                    if (note_idx == LAST_IDX) begin
                        song_done_nx = 1'b1;
                        state_nx     = DONE;
                    end else begin
                        note_idx_nx = note_idx + 1'b1;
                        state_nx    = FETCH;
                    end
                end
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: a song-position model predicts each
// note/end event and its cycle; a negedge monitor pops and compares.
module tb_song_reader;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;
    localparam int IDX_W  = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    song_reader_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) bus ();

    song_reader #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [11:0] rom [0:127];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int nn_count = 0;

    typedef struct {
        bit         done;
        logic [5:0] n;
        logic [5:0] d;
        int         cyc;
    } exp_t;

    exp_t q[$];

    int m_idx  = 0;
    bit m_done = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.new_note === 1'b1) nn_count++;
        if (bus.new_note === 1'b1 || bus.song_done === 1'b1) begin
            check("pulse_exclusive", int'(bus.new_note & bus.song_done), 0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: new_note=%0d song_done=%0d expected none (cycle %0d)",
                         bus.new_note, bus.song_done, cyc);
            end else begin
                e = q.pop_front();
                check("event_kind_song_done", int'(bus.song_done), int'(e.done));
                check("event_cycle", cyc, e.cyc);
                if (!e.done) begin
                    check("event_note", int'(bus.note), int'(e.n));
                    check("event_duration", int'(bus.duration), int'(e.d));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [1:0] s);
        logic [6:0] a;
        for (int i = 0; i < 32; i++) begin
            a = {s, 5'(i)};
            rom[a] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        end
    endtask

    task automatic do_reset(input logic [1:0] s);
        reset         = 1'b1;
        bus.play      = 1'b0;
        bus.note_done = 1'b0;
        bus.song      = s;
        tick();
        reset  = 1'b0;
        m_idx  = 0;
        m_done = 1'b0;
    endtask

    // Expected response when the entry at the model's position is reached.
    task automatic push_entry(input int c);
        exp_t       e;
        logic [11:0] w;
        logic [6:0]  a;
        a      = {bus.song, 5'(m_idx)};
        w      = rom[a];
        e.n    = w[11:6];
        e.d    = w[5:0];
        e.done = (w[5:0] == 6'd0);
        e.cyc  = c;
        if (e.done) m_done = 1'b1;
        q.push_back(e);
    endtask

    task automatic start_play();
        bus.play = 1'b1;
        push_entry(cyc + 3);
    endtask

    task automatic pulse_done(input int extra);
        exp_t e;
        if (!m_done) begin
            if (m_idx == 31) begin
                e.done = 1'b1;
                e.n    = '0;
                e.d    = '0;
                e.cyc  = cyc + 1;
                m_done = 1'b1;
                q.push_back(e);
            end else begin
                m_idx++;
                push_entry(cyc + 3 + extra);
            end
        end
        bus.note_done = 1'b1;
        tick();
        bus.note_done = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && q.size() != 0; i++) tick();
        check(name, q.size(), 0);
    endtask

    initial begin
        logic [1:0] s;
        logic [5:0] hn, hd;
        logic [6:0] a;
        int         nn0;

        reset = 1'b1;
        bus.play = 1'b0;
        bus.note_done = 1'b0;
        bus.song = 2'd0;
        for (int i = 0; i < 128; i++) rom[i] = 12'($urandom_range(0, 4095));
        repeat (2) tick();

        // Basic read
        fill_rom(2'd1);
        rom[32] = {6'd10, 6'd8};
        rom[33] = {6'd12, 6'd4};
        do_reset(2'd1);
        check("reset_note", int'(bus.note), 0);
        check("reset_duration", int'(bus.duration), 0);
        check("reset_new_note", int'(bus.new_note), 0);
        check("reset_song_done", int'(bus.song_done), 0);
        check("basic_rom_addr0", int'(bus.rom_addr), 32);
        start_play();
        wait_drain("basic_first_note");
        check("basic_rom_addr0_hold", int'(bus.rom_addr), 32);
        pulse_done(0);
        check("basic_rom_addr1", int'(bus.rom_addr), 33);
        wait_drain("basic_second_note");

        // Pause gating while in WAIT_ROM
        hn = bus.note;
        hd = bus.duration;
        bus.play = 1'b0;
        pulse_done(5);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pause_note_hold", int'(bus.note), int'(hn));
            check("pause_duration_hold", int'(bus.duration), int'(hd));
        end
        bus.play = 1'b1;
        wait_drain("pause_resume_note");

        // End marker at index 2
        s = 2'($urandom_range(0, 3));
        fill_rom(s);
        a = {s, 5'd2};
        rom[a][5:0] = 6'd0;
        do_reset(s);
        start_play();
        wait_drain("end_note0");
        pulse_done(0);
        wait_drain("end_note1");
        hn = bus.note;
        hd = bus.duration;
        pulse_done(0);
        wait_drain("end_song_done");
        check("end_note_kept", int'(bus.note), int'(hn));
        check("end_duration_kept", int'(bus.duration), int'(hd));
        nn0 = nn_count;
        pulse_done(0);
        pulse_done(0);
        repeat (6) tick();
        check("end_ignore_note_done", nn_count, nn0);

        // Full song of 32 entries
        s = 2'($urandom_range(0, 3));
        fill_rom(s);
        do_reset(s);
        nn0 = nn_count;
        start_play();
        wait_drain("full_note0");
        for (int i = 0; i < 31; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_done(0);
            wait_drain("full_note");
        end
        check("full_new_note_count", nn_count - nn0, 32);
        pulse_done(0);
        wait_drain("full_song_done");
        check("full_rom_idx_last", int'(bus.rom_addr[4:0]), 31);
        pulse_done(0);
        repeat (6) tick();
        check("full_no_extra_note", nn_count - nn0, 32);
        check("full_rom_idx_stays", int'(bus.rom_addr[4:0]), 31);

        // Reset mid-note at index 5 with play held high
        s = 2'($urandom_range(0, 3));
        fill_rom(s);
        do_reset(s);
        start_play();
        wait_drain("midrst_note0");
        for (int i = 0; i < 5; i++) begin
            pulse_done(0);
            wait_drain("midrst_note");
        end
        check("midrst_idx5", int'(bus.rom_addr[4:0]), 5);
        reset = 1'b1;
        tick();
        check("midrst_note_zero", int'(bus.note), 0);
        check("midrst_duration_zero", int'(bus.duration), 0);
        check("midrst_rom_addr", int'(bus.rom_addr), int'({s, 5'd0}));
        reset  = 1'b0;
        m_idx  = 0;
        m_done = 1'b0;
        push_entry(cyc + 3);
        wait_drain("midrst_restart_note");

        // Reset and note_done in the same cycle
        for (int i = 0; i < 3; i++) begin
            pulse_done(0);
            wait_drain("simul_note");
        end
        nn0 = nn_count;
        reset = 1'b1;
        bus.note_done = 1'b1;
        bus.play = 1'b0;
        tick();
        reset = 1'b0;
        bus.note_done = 1'b0;
        m_idx  = 0;
        m_done = 1'b0;
        check("simul_rom_addr", int'(bus.rom_addr), int'({s, 5'd0}));
        check("simul_note_zero", int'(bus.note), 0);
        repeat (8) tick();
        check("simul_no_new_note", nn_count, nn0);
        check("simul_queue_empty", q.size(), 0);
        start_play();
        wait_drain("simul_restart_note");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
